skew_delay_line: RTL and testbench
==================================

# skew_delay_line

Parametrised multi-channel D-flop delay line with per-channel staggered depth, used to skew operand rows before they enter the systolic multiplier array. Each channel c delays its WIDTH-bit lane by BASE_DEPTH + c·STEP cycles in skew mode, or by BASE_DEPTH cycles in uniform mode. Adds stall (EN), per-stage valid tracking, synchronous flush and a drain sequence with completion pulse. Sits between the operand loader and the array edge.

## Interface
- WIDTH, 8, bits per channel lane
- CHANNELS, 4, number of lanes
- BASE_DEPTH, 1, delay of channel 0 in cycles; must be ≥1
- STEP, 1, extra delay per channel index in skew mode; ≥0
- SKEW, 1, 1 = staggered depths, 0 = all channels BASE_DEPTH
- CLK  input  1  rising-edge clock
- RST_N  input  1  synchronous active-low reset
- EN  input  1  advance all stages this cycle
- FLUSH  input  1  synchronous clear of all stages
- DRAIN  input  1  request to empty pipeline with bubbles
- IN_VALID  input  1  IN_DATA carries a sample (shared by all lanes)
- IN_DATA  input  CHANNELS·WIDTH  lane c at bits [c·WIDTH +: WIDTH]
- IN_READY  output  1  sample is accepted this cycle when high
- OUT_VALID  output  CHANNELS  per-lane valid of last stage
- OUT_DATA  output  CHANNELS·WIDTH  per-lane last-stage data
- BUSY  output  1  any stage of any lane holds a valid sample
- DONE  output  1  one-cycle pulse at drain completion

## Operation
- D(c) = BASE_DEPTH + (SKEW ? c·STEP : 0); DMAX = D(CHANNELS-1).
- Each lane: D(c) registered stages of {valid, data}. OUT is the last stage directly (no extra register).
- Advance: all lanes shift one stage; stage 0 loads {IN_VALID, IN_DATA lane} when IN_READY, else {0, 0}.
- IN_READY = EN && state != DRAINING. Sample accepted only if IN_VALID && IN_READY.
- Stall (advance condition false): every stage, OUT_VALID, OUT_DATA hold.
- FSM states IDLE, ACTIVE, DRAINING:
  - IDLE → ACTIVE on accepted sample.
  - ACTIVE → IDLE when BUSY would be 0 after the edge and no sample accepted.
  - ACTIVE → DRAINING on DRAIN.
  - IDLE with DRAIN → DONE pulses next cycle, stay IDLE.
  - DRAINING: advance every cycle regardless of EN, stage 0 loads bubbles; when all valids clear → DONE pulse, → IDLE.
- Advance condition = (EN && state != DRAINING) || state == DRAINING.
- FLUSH: all valid and data stages cleared to 0, state → IDLE, no DONE; overrides EN, DRAIN, IN_VALID same cycle.
- Priority: RST_N low > FLUSH > DRAIN > EN.
- Data passes unmodified; no arithmetic. Invalid stages carry 0 data.

## Timing
- Reset (RST_N low at edge): all stages 0, OUT_VALID = 0, OUT_DATA = 0, BUSY = 0, DONE = 0, state IDLE; IN_READY = 0 while reset asserted.
- Latency lane c: sample accepted at edge k appears on OUT lane c after edge k+D(c)-1 (i.e. visible D(c) advancing edges after capture counted from the capture edge inclusive), provided no stall; each stall cycle adds one.
- Throughput one sample per cycle per lane.
- Drain completes within DMAX cycles of entering DRAINING; DONE asserted exactly one cycle, same cycle BUSY first reads 0.
- Reset or FLUSH mid-drain: no DONE.
- BUSY is combinational OR of all stage valid bits.

## Structure
- Package skew_pkg: state enum (IDLE, ACTIVE, DRAINING); function depth_of(c, BASE_DEPTH, STEP, SKEW).
- Sub-module delay_chain: one lane, parameters WIDTH, DEPTH; ports CLK, RST_N, ADV, CLR, IN_V, IN_D, OUT_V, OUT_D, ANY_V. Top generates CHANNELS instances with DEPTH = depth_of(c) and owns FSM, IN_READY, DONE.

## Test plan
- Reset: hold RST_N low 3 cycles with IN_VALID=1, IN_DATA=0xFFFFFFFF → all outputs 0, IN_READY 0, BUSY 0.
- Skew: EN=1, single sample 0x44332211 → lane0 0x11 after 1 cycle, lane1 0x22 after 2, lane2 0x33 after 3, lane3 0x44 after 4; each OUT_VALID single-cycle.
- Stall: stream 0x01..0x08 on all lanes, drop EN for 2 cycles mid-stream → outputs freeze 2 cycles, sequence intact, no loss/duplication.
- Drain: stream 3 samples, assert DRAIN with EN=0 → pipeline advances, IN_READY 0, all samples exit, DONE one pulse ≤4 cycles later, state IDLE.
- Flush: 4 samples in flight, FLUSH and DRAIN same cycle → next cycle BUSY 0, OUT_VALID 0, no DONE.
- Uniform mode SKEW=0, BASE_DEPTH=3, CHANNELS=2: sample 0xBBAA → both lanes appear together after 3 cycles.

Source files
------------

// File: rtl/skew_pkg.sv
// rtl/skew_pkg.sv - shared state type and lane depth helper for the skew delay line
package skew_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    DRAINING = 2'd2
  } state_t;

  // Lane c is BASE_DEPTH stages deep, plus c*STEP more when staggering is enabled.
  function automatic int depth_of(input int c, input int base_depth, input int step, input int skew);
    return base_depth + ((skew != 0) ? c * step : 0);
  endfunction

endpackage

// File: rtl/delay_chain.sv
// rtl/delay_chain.sv - one lane of {valid, data} delay stages
module delay_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ADV,
  input  logic             CLR,
  input  logic             IN_V,
  input  logic [WIDTH-1:0] IN_D,
  output logic             OUT_V,
  output logic [WIDTH-1:0] OUT_D,
  output logic             ANY_V,
  output logic             MID_V
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // Shift the lane one stage per advance; bubbles carry zero data so idle stages read clean.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (ADV) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
      v[0] <= IN_V;
      d[0] <= IN_V ? IN_D : '0;
    end
  end

  // MID_V covers every stage except the last: what stays valid after an advance with a bubble input.
  always_comb begin
    MID_V = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      MID_V = MID_V | v[i];
    end
  end

  assign ANY_V = |v;
  assign OUT_V = v[DEPTH-1];
  assign OUT_D = d[DEPTH-1];

endmodule

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - multi-lane staggered delay line with stall, flush and drain
module skew_delay_line
  import skew_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int BASE_DEPTH = 1,
  parameter int STEP       = 1,
  parameter int SKEW       = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      FLUSH,
  input  logic                      DRAIN,
  input  logic                      IN_VALID,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  output logic                      IN_READY,
  output logic [CHANNELS-1:0]       OUT_VALID,
  output logic [CHANNELS*WIDTH-1:0] OUT_DATA,
  output logic                      BUSY,
  output logic                      DONE
);

  state_t              state;
  state_t              state_nxt;
  logic                done_nxt;
  logic                adv;
  logic                accept;
  logic                next_busy;
  logic [CHANNELS-1:0] any_v;
  logic [CHANNELS-1:0] mid_v;

  // FLUSH and DRAIN both outrank EN, so neither lets a sample in on the cycle they are raised.
  assign IN_READY  = RST_N && !FLUSH && !DRAIN && EN && (state != DRAINING);
  assign accept    = IN_VALID && IN_READY;
  assign adv       = (EN && (state != DRAINING)) || (state == DRAINING);
  assign BUSY      = |any_v;
  // Occupancy after this edge: a stall keeps everything, an advance drops each lane's last stage.
  assign next_busy = adv ? (accept || (|mid_v)) : BUSY;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    delay_chain #(
      .WIDTH(WIDTH),
      .DEPTH(depth_of(c, BASE_DEPTH, STEP, SKEW))
    ) u_chain (
      .CLK  (CLK),
      .RST_N(RST_N),
      .ADV  (adv),
      .CLR  (FLUSH),
      .IN_V (accept),
      .IN_D (IN_DATA[c*WIDTH +: WIDTH]),
      .OUT_V(OUT_VALID[c]),
      .OUT_D(OUT_DATA[c*WIDTH +: WIDTH]),
      .ANY_V(any_v[c]),
      .MID_V(mid_v[c])
    );
  end

  // Next state and completion pulse; DONE is registered so it lands on the first empty cycle.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (FLUSH) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (DRAIN) begin
            done_nxt = 1'b1;
          end else if (accept) begin
            state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          if (DRAIN) begin
            if (next_busy) begin
              state_nxt = DRAINING;
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else if (!next_busy) begin
            state_nxt = IDLE;
          end
        end
        DRAINING: begin
          if (!next_busy) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and DONE registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_skew_delay_line.sv
// tb/tb_skew_delay_line.sv - self-checking bench for skew_delay_line
module tb_skew_delay_line;

  localparam int W    = 8;
  localparam int C    = 4;
  localparam int BASE = 1;
  localparam int STP  = 1;
  localparam int SKW  = 1;
  localparam int DMAX = BASE + (C - 1) * STP;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, drain, in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done;
  logic [3:0]  out_valid;
  logic [31:0] out_data;

  logic        u_en, u_valid;
  logic [15:0] u_data;
  logic        u_ready, u_busy, u_done;
  logic [1:0]  u_ov;
  logic [15:0] u_od;

  int checks = 0;
  int errors = 0;

  // Reference model: samples keyed by the advance count at which they were captured.
  logic [31:0] smap [int];
  int          advc = 0;
  bit          draining = 0;
  bit          done_m = 0;

  typedef struct {
    logic        en, v, dr, fl;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  ov;
    logic [31:0] od;
    logic        bsy, dn;
  } vec_t;

  vec_t   tbl [14];
  logic [7:0] seen [$];

  always #5 clk = ~clk;

  skew_delay_line #(.WIDTH(W), .CHANNELS(C), .BASE_DEPTH(BASE), .STEP(STP), .SKEW(SKW)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .FLUSH(flush), .DRAIN(drain),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
    .OUT_VALID(out_valid), .OUT_DATA(out_data), .BUSY(busy), .DONE(done)
  );

  skew_delay_line #(.WIDTH(8), .CHANNELS(2), .BASE_DEPTH(3), .STEP(1), .SKEW(0)) dut_uni (
    .CLK(clk), .RST_N(rst_n), .EN(u_en), .FLUSH(1'b0), .DRAIN(1'b0),
    .IN_VALID(u_valid), .IN_DATA(u_data), .IN_READY(u_ready),
    .OUT_VALID(u_ov), .OUT_DATA(u_od), .BUSY(u_busy), .DONE(u_done)
  );

  function automatic int dep(input int c);
    return BASE + ((SKW != 0) ? c * STP : 0);
  endfunction

  function automatic logic exp_ready();
    return rst_n && !flush && !drain && en && !draining;
  endfunction

  function automatic logic [3:0] exp_ov();
    logic [3:0] r = '0;
    for (int c = 0; c < C; c++) begin
      if (smap.exists(advc - (dep(c) - 1))) r[c] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_od();
    logic [31:0] r = '0;
    logic [31:0] s;
    for (int c = 0; c < C; c++) begin
      if (smap.exists(advc - (dep(c) - 1))) begin
        s = smap[advc - (dep(c) - 1)];
        r[c*8 +: 8] = s[c*8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic m_step();
    bit acc, adv, busy_after;
    int stale [$];
    if (!rst_n || flush) begin
      smap.delete();
      draining = 0;
      done_m = 0;
    end else begin
      acc = in_valid && exp_ready();
      adv = en || draining;
      if (adv) begin
        advc++;
        if (acc) smap[advc] = in_data;
      end
      foreach (smap[k]) if (advc - k >= DMAX) stale.push_back(k);
      foreach (stale[j]) smap.delete(stale[j]);
      busy_after = (smap.size() != 0);
      done_m = 0;
      if (draining) begin
        if (!busy_after) begin
          draining = 0;
          done_m = 1;
        end
      end else if (drain) begin
        if (busy_after) draining = 1;
        else done_m = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic half1();
    #2;
    chk("in_ready", in_ready, exp_ready());
  endtask

  task automatic half2();
    @(posedge clk);
    m_step();
    #1;
    chk("out_valid", out_valid, exp_ov());
    chk("out_data", out_data, exp_od());
    chk("busy", busy, smap.size() != 0);
    chk("done", done, done_m);
  endtask

  task automatic tick();
    half1();
    half2();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h44332211, 1'b1, 4'b0001, 32'h00000011, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0010, 32'h00002200, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0100, 32'h00330000, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b1000, 32'h44000000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h01010101, 1'b1, 4'b0001, 32'h00000001, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h02020202, 1'b1, 4'b0011, 32'h00000102, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h03030303, 1'b1, 4'b0111, 32'h00010203, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 4'b0111, 32'h00010203, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hEEEEEEEE, 1'b0, 4'b1110, 32'h01020300, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hEEEEEEEE, 1'b0, 4'b1100, 32'h02030000, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hEEEEEEEE, 1'b0, 4'b1000, 32'h03000000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hEEEEEEEE, 1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b0};

    u_en = 1'b0; u_valid = 1'b0; u_data = '0;

    // Reset held three cycles with a valid all-ones sample offered.
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; drain = 1'b0; in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    repeat (3) begin
      tick();
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_ov", out_valid, 4'b0000);
      chk("rst_od", out_data, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    rst_n = 1'b1;

    // Skew walk-through and drain with EN low, from the vector table.
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; in_valid = tbl[i].v; drain = tbl[i].dr; flush = tbl[i].fl; in_data = tbl[i].d;
      half1();
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      half2();
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_od", i), out_data, tbl[i].od);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
    end

    // Stream 1..8 with a two-cycle stall after sample 4; lane 3 must see each sample once.
    drain = 1'b0; flush = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] b;
      if (i == 5) begin
        en = 1'b0; in_valid = 1'b1; in_data = 32'h05050505;
        repeat (2) begin
          tick();
          chk("stall_hold_l0", out_data[7:0], 8'h04);
          chk("stall_hold_v0", out_valid[0], 1'b1);
        end
      end
      b = i[7:0];
      en = 1'b1; in_valid = 1'b1; in_data = {4{b}};
      tick();
      if (out_valid[3]) seen.push_back(out_data[31:24]);
    end
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid[3]) seen.push_back(out_data[31:24]);
    end
    chk("stall_count", seen.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) chk($sformatf("stall_seq%0d", i), seen[i], i + 1);
    end

    // Flush and drain raised together with four samples in flight.
    en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h10101010 + i;
      tick();
    end
    flush = 1'b1; drain = 1'b1;
    tick();
    chk("flush_busy", busy, 1'b0);
    chk("flush_ov", out_valid, 4'b0000);
    chk("flush_done", done, 1'b0);
    flush = 1'b0; drain = 1'b0; en = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_done_next", done, 1'b0);
    chk("flush_busy_next", busy, 1'b0);

    // Uniform instance: both lanes emerge together on the third edge.
    u_en = 1'b1; u_valid = 1'b1; u_data = 16'hBBAA;
    tick();
    u_valid = 1'b0; u_data = '0;
    chk("uni_e1_ov", u_ov, 2'b00);
    chk("uni_e1_busy", u_busy, 1'b1);
    tick();
    chk("uni_e2_ov", u_ov, 2'b00);
    tick();
    chk("uni_e3_ov", u_ov, 2'b11);
    chk("uni_e3_od", u_od, 16'hBBAA);
    tick();
    chk("uni_e4_ov", u_ov, 2'b00);
    chk("uni_e4_busy", u_busy, 1'b0);
    u_en = 1'b0;

    // Randomised traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      rst_n    = ($urandom_range(99) != 0);
      en       = ($urandom_range(3) != 0);
      in_valid = ($urandom_range(4) < 3);
      in_data  = $urandom;
      drain    = ($urandom_range(19) == 0);
      flush    = ($urandom_range(29) == 0);
      tick();
    end

    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; drain = 1'b0; flush = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
